// File: rtl/pwm_generator.sv
// PWM core: shadow-loaded period/pulse/size, optional finite burst, registered outputs.
// Build option: define PWM_IMMEDIATE_STOP_EN to abort a run as soon as enable_i drops.
module pwm_generator #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SIZE_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] period_i,
   input  logic [DATA_WIDTH-1:0] pulse_i,
   input  logic [SIZE_WIDTH-1:0] size_i,
   input  logic                  enable_i,
   output logic                  pwm_o,
   output logic                  period_end_o,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] cnt_q;
   logic [DATA_WIDTH-1:0] period_q;
   logic [DATA_WIDTH-1:0] pulse_q;
   logic [SIZE_WIDTH-1:0] burst_q;
   logic [SIZE_WIDTH-1:0] size_q;
   logic                  pwm_q;
   logic                  period_end_q;
   logic                  busy_q;
   logic                  done_q;

   logic [DATA_WIDTH-1:0] cnt_inc;
   logic [SIZE_WIDTH-1:0] burst_inc;
   logic                  last_cycle;
   logic                  burst_last;
   logic                  start_ok;
   logic                  stop_now;

   assign cnt_inc    = cnt_q + DATA_WIDTH'(1);
   assign burst_inc  = burst_q + SIZE_WIDTH'(1);
   assign last_cycle = (cnt_q == period_q - DATA_WIDTH'(1));
   assign burst_last = (size_q != '0) && (burst_inc == size_q);
   // A (re)load is only legal with enable high and a non-zero period.
   assign start_ok   = enable_i && (period_i != '0);

`ifdef PWM_IMMEDIATE_STOP_EN
   assign stop_now = !enable_i;
`else
   assign stop_now = 1'b0;
`endif

   // Outputs are registered from the next-cycle counter value so they line up with cnt_q.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         period_q     <= '0;
         pulse_q      <= '0;
         burst_q      <= '0;
         size_q       <= '0;
         pwm_q        <= 1'b0;
         period_end_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start_ok) begin
                  state_q      <= StRun;
                  period_q     <= period_i;
                  pulse_q      <= pulse_i;
                  size_q       <= size_i;
                  cnt_q        <= '0;
                  burst_q      <= '0;
                  pwm_q        <= (pulse_i != '0);
                  period_end_q <= (period_i == DATA_WIDTH'(1));
                  busy_q       <= 1'b1;
               end
            end
            StRun: begin
               if (stop_now) begin
                  state_q      <= StIdle;
                  pwm_q        <= 1'b0;
                  period_end_q <= 1'b0;
                  busy_q       <= 1'b0;
               end else if (!last_cycle) begin
                  cnt_q        <= cnt_inc;
                  pwm_q        <= (cnt_inc < pulse_q);
                  period_end_q <= (cnt_inc == period_q - DATA_WIDTH'(1));
               end else begin
                  burst_q <= burst_inc;
                  if (burst_last) begin
                     state_q      <= StDone;
                     pwm_q        <= 1'b0;
                     period_end_q <= 1'b0;
                     busy_q       <= 1'b0;
                     done_q       <= 1'b1;
                  end else if (start_ok) begin
                     period_q     <= period_i;
                     pulse_q      <= pulse_i;
                     size_q       <= size_i;
                     cnt_q        <= '0;
                     pwm_q        <= (pulse_i != '0);
                     period_end_q <= (period_i == DATA_WIDTH'(1));
                  end else begin
                     state_q      <= StIdle;
                     pwm_q        <= 1'b0;
                     period_end_q <= 1'b0;
                     busy_q       <= 1'b0;
                  end
               end
            end
            StDone: begin
               if (!enable_i) begin
                  state_q <= StIdle;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q      <= StIdle;
               pwm_q        <= 1'b0;
               period_end_q <= 1'b0;
               busy_q       <= 1'b0;
               done_q       <= 1'b0;
            end
         endcase
      end
   end

   assign pwm_o        = pwm_q;
   assign period_end_o = period_end_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule
